mac_accumulate_module: RTL and testbench

Downstream consumer of the pipelined LUT multiplier: accumulates a stream of 16-bit signed products into frames (dot products), saturating on overflow, and presents each frame result on a valid/ready output port. The multiplier has a fixed latency and no backpressure, so this block never stalls its input. Instead it double-buffers the result and reports any frame it must drop.

---
 rtl/mac_accumulate_module_pkg.sv | 33 +++
 rtl/mac_accumulate_module_if.sv | 31 +++
 rtl/mac_accumulate_module_sat_add.sv | 28 ++
 rtl/mac_accumulate_module.sv | 106 ++++++++++
 tb/tb_mac_accumulate_module.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mac_accumulate_module_pkg.sv
// Shared definitions for the MAC accumulate stage and future accumulating stages.
//   ACC_W_DEF / MAX_LEN_DEF : default accumulator width and maximum frame length
//   PROD_W / LEN_W          : product input width and frame-length field width
//   acc_state_e / out_state_e : accumulator-side and output-side state encodings
//   sat_max_val / sat_min_val : signed saturation limits for a given width
package mac_accumulate_module_pkg;

  localparam int unsigned ACC_W_DEF   = 24;
  localparam int unsigned MAX_LEN_DEF = 256;
  localparam int unsigned PROD_W      = 16;
  localparam int unsigned LEN_W       = 9;

  typedef enum logic {
    ACC_IDLE  = 1'b0,
    ACC_ACCUM = 1'b1
  } acc_state_e;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

  // Largest positive value representable in w-bit two's complement.
  function automatic longint sat_max_val(int unsigned w);
    return (longint'(1) <<< (w - 1)) - longint'(1);
  endfunction

  // Most negative value representable in w-bit two's complement.
  function automatic longint sat_min_val(int unsigned w);
    return -(longint'(1) <<< (w - 1));
  endfunction

endpackage

// File: rtl/mac_accumulate_module_if.sv
// Product-in / result-out bus of the MAC accumulate stage.
//   prod_valid, prod_last, product : product stream from the multiplier (no backpressure)
//   res_valid, res_ready           : result handshake
//   res_sum, res_len, res_sat      : frame result payload
// slave = the accumulator, master = the producer/consumer pair around it.
interface mac_accumulate_module_if
  import mac_accumulate_module_pkg::*;
#(
  parameter int unsigned ACC_W = ACC_W_DEF
);

  logic                     prod_valid;
  logic                     prod_last;
  logic signed [PROD_W-1:0] product;
  logic                     res_valid;
  logic                     res_ready;
  logic signed [ACC_W-1:0]  res_sum;
  logic [LEN_W-1:0]         res_len;
  logic                     res_sat;

  modport slave (
    input  prod_valid, prod_last, product, res_ready,
    output res_valid, res_sum, res_len, res_sat
  );

  modport master (
    output prod_valid, prod_last, product, res_ready,
    input  res_valid, res_sum, res_len, res_sat
  );

endinterface

// File: rtl/mac_accumulate_module_sat_add.sv
// Combinational signed ACC_W + ACC_W saturating adder.
//   a, b   : signed operands
//   sum_c  : sum clamped to the signed ACC_W range
//   ovf_c  : signed overflow occurred (sum_c is a clamp value)
module sat_add_module
  import mac_accumulate_module_pkg::*;
#(
  parameter int unsigned ACC_W = ACC_W_DEF
) (
  input  logic signed [ACC_W-1:0] a,
  input  logic signed [ACC_W-1:0] b,
  output logic signed [ACC_W-1:0] sum_c,
  output logic                    ovf_c
);

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(sat_max_val(ACC_W));
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(sat_min_val(ACC_W));

  logic [ACC_W:0] wide_c;

  // One guard bit: overflow iff the guard and the result sign disagree.
  assign wide_c = {a[ACC_W-1], a} + {b[ACC_W-1], b};
  assign ovf_c  = wide_c[ACC_W] ^ wide_c[ACC_W-1];

  // On overflow both operands share a sign, so a's sign picks the clamp.
  assign sum_c = ovf_c ? (a[ACC_W-1] ? SAT_MIN : SAT_MAX) : signed'(wide_c[ACC_W-1:0]);

endmodule

// File: rtl/mac_accumulate_module.sv
// Frame accumulator: sums a stream of signed 16-bit products into saturated
// frame results, double-buffered on a valid/ready output port.
//   clk, rst : clock, synchronous active-high reset
//   io       : product input and result output bus (slave side)
//   drop     : one-cycle pulse when a completed frame had to be discarded
//   busy     : a frame is open (at least one product accumulated)
module mac_accumulate_module
  import mac_accumulate_module_pkg::*;
#(
  parameter int unsigned ACC_W   = ACC_W_DEF,
  parameter int unsigned MAX_LEN = MAX_LEN_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  mac_accumulate_module_if.slave  io,
  output logic                    drop,
  output logic                    busy
);

  acc_state_e              acc_state;
  out_state_e              out_state;
  logic signed [ACC_W-1:0] acc;
  logic [LEN_W-1:0]        count;
  logic                    sat;

  logic signed [ACC_W-1:0] res_sum;
  logic [LEN_W-1:0]        res_len;
  logic                    res_sat;

  logic signed [ACC_W-1:0] prod_ext_c;
  logic signed [ACC_W-1:0] add_sum_c;
  logic                    add_ovf_c;
  logic signed [ACC_W-1:0] next_sum_c;
  logic                    next_sat_c;
  logic                    close_c;

  assign prod_ext_c = ACC_W'(io.product);

  sat_add_module #(.ACC_W(ACC_W)) u_sat_add (
    .a     (acc),
    .b     (prod_ext_c),
    .sum_c (add_sum_c),
    .ovf_c (add_ovf_c)
  );

  // The first product of a frame seeds the sum; later ones go through the clamp.
  assign next_sum_c = (acc_state == ACC_IDLE) ? prod_ext_c : add_sum_c;
  assign next_sat_c = (acc_state == ACC_IDLE) ? 1'b0 : (sat | add_ovf_c);

  // Close on an explicit last or when this product makes the frame MAX_LEN long.
  assign close_c = io.prod_valid && (io.prod_last || (count == LEN_W'(MAX_LEN - 1)));

  // Accumulator, result register and drop/busy flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_state <= ACC_IDLE;
      out_state <= OUT_EMPTY;
      acc       <= '0;
      count     <= '0;
      sat       <= 1'b0;
      res_sum   <= '0;
      res_len   <= '0;
      res_sat   <= 1'b0;
      drop      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      drop <= 1'b0;

      // Consumer transfer; a close in the same cycle below refills the slot.
      if ((out_state == OUT_FULL) && io.res_ready) begin
        out_state <= OUT_EMPTY;
      end

      if (io.prod_valid) begin
        if (close_c) begin
          acc       <= '0;
          count     <= '0;
          sat       <= 1'b0;
          acc_state <= ACC_IDLE;
          busy      <= 1'b0;
          if ((out_state == OUT_EMPTY) || io.res_ready) begin
            res_sum   <= next_sum_c;
            res_len   <= count + LEN_W'(1);
            res_sat   <= next_sat_c;
            out_state <= OUT_FULL;
          end else begin
            // Unconsumed result is kept; the new frame is lost.
            drop <= 1'b1;
          end
        end else begin
          acc       <= next_sum_c;
          count     <= count + LEN_W'(1);
          sat       <= next_sat_c;
          acc_state <= ACC_ACCUM;
          busy      <= 1'b1;
        end
      end
    end
  end

  assign io.res_valid = (out_state == OUT_FULL);
  assign io.res_sum   = res_sum;
  assign io.res_len   = res_len;
  assign io.res_sat   = res_sat;

endmodule

// File: tb/tb_mac_accumulate_module.sv
// Self-checking bench: two accumulators (24-bit/256 and 17-bit/4) share one
// product stream; a frame-level reference model predicts every output.
module tb_mac_accumulate_module;
  import mac_accumulate_module_pkg::*;

  localparam int unsigned W0 = 24;
  localparam int unsigned L0 = 256;
  localparam int unsigned W1 = 17;
  localparam int unsigned L1 = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        pv;
  logic        pl;
  logic [15:0] prod;
  logic        rr;
  logic        drop0, busy0, drop1, busy1;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mac_accumulate_module_if #(.ACC_W(W0)) if0 ();
  mac_accumulate_module_if #(.ACC_W(W1)) if1 ();

  assign if0.prod_valid = pv;
  assign if0.prod_last  = pl;
  assign if0.product    = prod;
  assign if0.res_ready  = rr;
  assign if1.prod_valid = pv;
  assign if1.prod_last  = pl;
  assign if1.product    = prod;
  assign if1.res_ready  = rr;

  mac_accumulate_module #(.ACC_W(W0), .MAX_LEN(L0)) dut0 (
    .clk  (clk),
    .rst  (rst),
    .io   (if0.slave),
    .drop (drop0),
    .busy (busy0)
  );

  mac_accumulate_module #(.ACC_W(W1), .MAX_LEN(L1)) dut1 (
    .clk  (clk),
    .rst  (rst),
    .io   (if1.slave),
    .drop (drop1),
    .busy (busy1)
  );

  // Reference model: running frame total with integer clamping, one-slot result.
  longint m_acc [2];
  int     m_cnt [2];
  bit     m_sat [2];
  bit     m_full[2];
  longint m_rsum[2];
  int     m_rlen[2];
  bit     m_rsat[2];
  bit     m_drop[2];
  longint wmax  [2];
  longint wmin  [2];
  int     mlen  [2];

  function automatic void model_step(int m, bit r, bit v, bit last, int p, bit ready);
    longint s;
    bit     fs;
    if (r) begin
      m_acc[m] = 0; m_cnt[m] = 0; m_sat[m] = 0; m_full[m] = 0;
      m_rsum[m] = 0; m_rlen[m] = 0; m_rsat[m] = 0; m_drop[m] = 0;
      return;
    end
    m_drop[m] = 0;
    if (m_full[m] && ready) m_full[m] = 0;
    if (v) begin
      if (m_cnt[m] == 0) begin
        s = p; fs = 0;
      end else begin
        s = m_acc[m] + p; fs = m_sat[m];
      end
      if (s > wmax[m]) begin
        s = wmax[m]; fs = 1;
      end else if (s < wmin[m]) begin
        s = wmin[m]; fs = 1;
      end
      m_cnt[m] = m_cnt[m] + 1;
      if (last || m_cnt[m] == mlen[m]) begin
        if (!m_full[m]) begin
          m_rsum[m] = s; m_rlen[m] = m_cnt[m]; m_rsat[m] = fs; m_full[m] = 1;
        end else begin
          m_drop[m] = 1;
        end
        m_acc[m] = 0; m_cnt[m] = 0; m_sat[m] = 0;
      end else begin
        m_acc[m] = s; m_sat[m] = fs;
      end
    end
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(string ph);
    chk({ph, ".valid0"}, 64'(if0.res_valid), 64'(m_full[0]));
    chk({ph, ".sum0"},   64'(if0.res_sum),   64'(W0'(m_rsum[0])));
    chk({ph, ".len0"},   64'(if0.res_len),   64'(m_rlen[0]));
    chk({ph, ".sat0"},   64'(if0.res_sat),   64'(m_rsat[0]));
    chk({ph, ".drop0"},  64'(drop0),         64'(m_drop[0]));
    chk({ph, ".busy0"},  64'(busy0),         64'(m_cnt[0] != 0));
    chk({ph, ".valid1"}, 64'(if1.res_valid), 64'(m_full[1]));
    chk({ph, ".sum1"},   64'(if1.res_sum),   64'(W1'(m_rsum[1])));
    chk({ph, ".len1"},   64'(if1.res_len),   64'(m_rlen[1]));
    chk({ph, ".sat1"},   64'(if1.res_sat),   64'(m_rsat[1]));
    chk({ph, ".drop1"},  64'(drop1),         64'(m_drop[1]));
    chk({ph, ".busy1"},  64'(busy1),         64'(m_cnt[1] != 0));
  endtask

  // One clock: drive inputs, advance model at the edge, check 1 time unit later.
  task automatic step(bit r, bit v, bit last, int p, bit ready, string ph);
    rst  = r;
    pv   = v;
    pl   = last;
    prod = 16'(p);
    rr   = ready;
    @(posedge clk);
    model_step(0, r, v, last, p, ready);
    model_step(1, r, v, last, p, ready);
    #1;
    check_all(ph);
  endtask

  initial begin
    wmax[0] = (longint'(1) <<< (W0 - 1)) - 1;
    wmin[0] = -(longint'(1) <<< (W0 - 1));
    wmax[1] = (longint'(1) <<< (W1 - 1)) - 1;
    wmin[1] = -(longint'(1) <<< (W1 - 1));
    mlen[0] = L0;
    mlen[1] = L1;

    // Reset state
    step(1, 0, 0, 0, 0, "rst");
    step(1, 0, 0, 0, 0, "rst");
    chk("rst_valid", 64'(if0.res_valid), 64'(0));
    chk("rst_busy",  64'(busy0),         64'(0));

    // Basic dot product 100 - 30 + 7
    step(0, 1, 0, 100, 1, "dot");
    chk("dot_busy", 64'(busy0), 64'(1));
    step(0, 1, 0, -30, 1, "dot");
    step(0, 1, 1, 7,   1, "dot");
    chk("dot_valid", 64'(if0.res_valid), 64'(1));
    chk("dot_sum",   64'(if0.res_sum),   64'(77));
    chk("dot_len",   64'(if0.res_len),   64'(3));
    chk("dot_sat",   64'(if0.res_sat),   64'(0));
    chk("dot_idle",  64'(busy0),         64'(0));
    step(0, 0, 0, 0, 1, "dot");

    // Positive saturation on the 17-bit instance, sticky through the +5
    step(0, 1, 0, 32767, 1, "satp");
    step(0, 1, 0, 32767, 1, "satp");
    step(0, 1, 1, 5,     1, "satp");
    chk("satp_sum1", 64'(if1.res_sum), 64'(65535));
    chk("satp_sat1", 64'(if1.res_sat), 64'(1));
    chk("satp_sum0", 64'(if0.res_sum), 64'(65539));
    // Negative saturation
    step(0, 1, 0, -32768, 1, "satn");
    step(0, 1, 0, -32768, 1, "satn");
    step(0, 1, 1, -32768, 1, "satn");
    chk("satn_sum1", 64'(if1.res_sum), 64'(-65536));
    chk("satn_sat1", 64'(if1.res_sat), 64'(1));
    step(0, 0, 0, 0, 1, "satn");

    // Auto-close at MAX_LEN, then a new frame opens
    for (int i = 0; i < 256; i++) step(0, 1, 0, 1, 1, "auto");
    chk("auto_valid", 64'(if0.res_valid), 64'(1));
    chk("auto_len",   64'(if0.res_len),   64'(256));
    chk("auto_sum",   64'(if0.res_sum),   64'(256));
    chk("auto_busy",  64'(busy0),         64'(0));
    step(0, 1, 0, 1, 1, "auto");
    chk("auto_reopen", 64'(busy0), 64'(1));
    step(0, 1, 1, 1, 1, "auto");
    step(0, 0, 0, 0, 1, "auto");

    // Drop while the result slot is held
    step(0, 1, 1, 5, 0, "drop");
    step(0, 1, 1, 9, 0, "drop");
    chk("drop_pulse", 64'(drop0),       64'(1));
    chk("drop_keep",  64'(if0.res_sum), 64'(5));
    step(0, 0, 0, 0, 0, "drop");
    chk("drop_once",  64'(drop0),       64'(0));
    step(0, 0, 0, 0, 1, "drop");
    chk("drop_xfer",  64'(if0.res_valid), 64'(0));

    // Close coincident with a transfer
    step(0, 1, 1, 4,  0, "swap");
    step(0, 1, 1, -2, 1, "swap");
    chk("swap_valid", 64'(if0.res_valid), 64'(1));
    chk("swap_sum",   64'(if0.res_sum),   64'(-2));
    chk("swap_drop",  64'(drop0),         64'(0));
    step(0, 0, 0, 0, 1, "swap");

    // Reset mid-frame while full
    step(0, 1, 1, 4, 0, "mrst");
    step(0, 1, 0, 1, 0, "mrst");
    step(0, 1, 0, 2, 0, "mrst");
    step(1, 0, 0, 0, 0, "mrst");
    chk("mrst_valid", 64'(if0.res_valid), 64'(0));
    chk("mrst_sum",   64'(if0.res_sum),   64'(0));
    chk("mrst_busy",  64'(busy0),         64'(0));
    step(0, 1, 1, 3, 0, "mrst");
    chk("mrst_sum3",  64'(if0.res_sum),   64'(3));
    chk("mrst_len1",  64'(if0.res_len),   64'(1));

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      bit r, v, last, ready;
      int p;
      r     = ($urandom_range(0, 299) == 0);
      v     = ($urandom_range(0, 3) != 0);
      last  = ($urandom_range(0, 7) == 0);
      ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 3) == 0)
        p = ($urandom_range(0, 1) == 0) ? 32767 : -32768;
      else
        p = int'($signed(16'($urandom)));
      step(r, v, last, p, ready, "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
